rr_bus_arbiter: RTL and testbench
=================================

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (legal range 2..16).
REQ-002 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive grant cycles before forced rotation (legal range 1..256).
REQ-003 Parameter ID_W, default $clog2(NUM_REQ), SHALL set the width of gnt_id.
REQ-004 Port clk, input, 1 bit, SHALL be the single rising-edge clock for all state.
REQ-005 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-006 Port req, input, NUM_REQ bits, SHALL carry one request bit per requester.
REQ-007 Port lock, input, NUM_REQ bits, SHALL let the matching requester extend its grant beyond MAX_HOLD.
REQ-008 Port gnt, output, NUM_REQ bits, SHALL be a registered one-hot grant, or all-zero when idle.
REQ-009 Port gnt_valid, output, 1 bit, SHALL be high exactly when gnt is non-zero.
REQ-010 Port gnt_id, output, ID_W bits, SHALL give the binary index of the granted requester, and 0 when idle.

Function
REQ-011 The state machine SHALL have two states: IDLE (no owner) and OWNED (one owner).
REQ-012 All outputs SHALL be registered; a request first sampled at edge N SHALL give its grant visible after edge N (one-cycle latency).
REQ-013 Selection SHALL be the first asserted req bit at or above rr_ptr, searching upward and wrapping from NUM_REQ-1 to 0.
REQ-014 On every new grant, rr_ptr SHALL become (granted index + 1) mod NUM_REQ.
REQ-015 From IDLE with req != 0, the arbiter SHALL go to OWNED with the selected owner; with req == 0 it SHALL stay in IDLE.
REQ-016 In OWNED, when req[owner] drops, the arbiter SHALL on the same edge either grant the next selected requester (no idle bubble) or go to IDLE if req == 0.
REQ-017 hold_cnt SHALL clear on each new grant and increment each OWNED cycle, saturating at MAX_HOLD-1.
REQ-018 Forced rotation SHALL occur when hold_cnt == MAX_HOLD-1, req[owner]=1, lock[owner]=0, and some other req bit is set: the grant SHALL then pass to the next selected requester other than the owner.
REQ-019 When lock[owner]=1, the grant SHALL hold for as long as req[owner]=1, regardless of hold_cnt.
REQ-020 A sole requester SHALL keep its grant indefinitely; it SHALL not be rotated, and the grant SHALL not toggle.
REQ-021 Simultaneous requests SHALL be resolved only by REQ-013; there SHALL be no fixed priority other than rr_ptr.
REQ-022 lock bits of non-owners SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req was low at the preceding edge.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, rr_ptr=0, hold_cnt=0.
REQ-025 A reset asserted mid-grant SHALL revoke the grant on that edge, with no further handshake.
REQ-026 After reset releases, requester 0 SHALL win any contention it takes part in first.

Structure
REQ-027 The shared package arb_pkg SHALL hold the state enum (IDLE, OWNED) and the default values of NUM_REQ and MAX_HOLD.
REQ-028 The combinational wrap-around search SHALL be one sub-module, rr_pick (inputs req and ptr; outputs one-hot, index, any).
REQ-029 The top module SHALL hold the state, owner, rr_ptr and hold_cnt registers.

Verification (NUM_REQ=4, MAX_HOLD=4)
REQ-030 Hold rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0 throughout; after release, the next edge gives gnt=4'b0001 and gnt_id=0.
REQ-031 Hold req=4'b1111 with lock=0 -> grant sequence 0,1,2,3,0 with each grant held exactly 4 cycles, and no idle cycle between grants.
REQ-032 Grant to 2, then drop req[2] while req=4'b1001 -> next edge gnt=4'b1000 (index 3 wins by wrap order from ptr=3).
REQ-033 Grant to 1 with lock[1]=1 and req=4'b1111 for 20 cycles -> gnt=4'b0010 for all 20 cycles; then deassert lock[1] -> rotation to 2 within 1 cycle (hold_cnt already saturated).
REQ-034 Hold only req[3]=1 for 50 cycles -> gnt=4'b1000 constant; drop req[3] -> next edge gnt=0 and gnt_valid=0.
REQ-035 Pulse rst_n=0 for 1 cycle while requester 2 owns the bus -> gnt=0 on that edge, and rr_ptr returns to 0 (req=4'b0101 then grants 0 first).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// State encoding and default sizing parameters.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around first-set search starting at ptr.
// Returns one-hot, binary index and an any-set flag.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    index,
    output logic               any
);

    // scan upward from ptr, wrapping at NUM_REQ-1, first hit wins
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                index     = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with hold limit and per-requester lock.
// Registered one-hot grant, one-cycle request-to-grant latency.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    arb_state_t         state;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    rr_ptr;
    logic [HW-1:0]      hold_cnt;

    logic [NUM_REQ-1:0] owner_bit;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               others;
    logic               keep;

    // owner is excluded from the search, so a rotation never re-picks it
    always_comb begin
        owner_bit = '0;
        pick_req  = req;
        others    = 1'b0;
        keep      = 1'b0;
        if (state == OWNED) begin
            owner_bit = NUM_REQ'(1) << owner;
            pick_req  = req & ~owner_bit;
            others    = |pick_req;
            keep      = req[owner] &&
                        (lock[owner] || hold_cnt != HOLD_MAX || !others);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // state, owner, pointer, hold counter and registered grant outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else if (keep) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
        end else if (pick_any) begin
            state     <= OWNED;
            owner     <= pick_idx;
            hold_cnt  <= '0;
            gnt       <= pick_oh;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_idx;
            if (int'(pick_idx) == NUM_REQ - 1) rr_ptr <= '0;
            else rr_ptr <= pick_idx + ID_W'(1);
        end else begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter (NUM_REQ=4, MAX_HOLD=4).
// Directed scenarios followed by randomized traffic.
module tb_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    typedef struct packed {
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    int checks;
    int errors;
    exp_t exp_q[$];

    int m_owner;
    int m_ptr;
    int m_hold;

    rr_bus_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH),
        .ID_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: owner as integer (-1 idle), pointer and hold count
    function automatic void model_step(logic [3:0] r, logic [3:0] l,
                                       logic rs);
        int others;
        int found;
        if (!rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            return;
        end
        others = 0;
        for (int j = 0; j < N; j++)
            if (r[j] && j != m_owner) others = 1;
        if (m_owner >= 0 && r[m_owner] &&
            (l[m_owner] || m_hold < MH - 1 || others == 0)) begin
            if (m_hold < MH - 1) m_hold = m_hold + 1;
            return;
        end
        found = -1;
        for (int s = 0; s < N; s++) begin
            int j;
            j = (m_ptr + s) % N;
            if (found < 0 && r[j] && j != m_owner) found = j;
        end
        m_owner = found;
        m_hold  = 0;
        if (found >= 0) m_ptr = (found + 1) % N;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (m_owner >= 0) begin
            e.g  = 4'(1 << m_owner);
            e.v  = 1'b1;
            e.id = 2'(m_owner);
        end
        return e;
    endfunction

    task automatic cycle(logic [3:0] r, logic [3:0] l, logic rs);
        @(negedge clk);
        req   = r;
        lock  = l;
        rst_n = rs;
        model_step(r, l, rs);
        exp_q.push_back(model_out());
    endtask

    task automatic check_now(string name, logic [3:0] eg, logic ev);
        @(posedge clk);
        #2;
        checks++;
        if (gnt !== eg || gnt_valid !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%b valid=%b, want gnt=%b valid=%b",
                     name, gnt, gnt_valid, eg, ev);
        end
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({gnt, gnt_valid, gnt_id} !== e) begin
                    errors++;
                    $display("FAIL sb: got gnt=%b v=%b id=%0d, want gnt=%b v=%b id=%0d",
                             gnt, gnt_valid, gnt_id, e.g, e.v, e.id);
                end
                checks++;
                if ($countones(gnt) > 1) begin
                    errors++;
                    $display("FAIL onehot: got gnt=%b, want at most one bit",
                             gnt);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        req     = '0;
        lock    = '0;
        rst_n   = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        checks  = 0;
        errors  = 0;

        // reset with all requesting, then release
        cycle(4'b1111, 4'b0000, 1'b0);
        check_now("in_reset", 4'b0000, 1'b0);
        cycle(4'b1111, 4'b0000, 1'b0);
        cycle(4'b1111, 4'b0000, 1'b1);
        check_now("rst_release", 4'b0001, 1'b1);
        // full contention rotation 0,1,2,3,0
        repeat (17) cycle(4'b1111, 4'b0000, 1'b1);
        check_now("rotate_back_0", 4'b0001, 1'b1);

        // grant to 2, then 2 drops with 0 and 3 requesting
        cycle(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b1001, 4'b0000, 1'b1);
        check_now("wrap_to_3", 4'b1000, 1'b1);

        // locked owner survives hold limit
        cycle(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0010, 4'b0010, 1'b1);
        repeat (20) cycle(4'b1111, 4'b0010, 1'b1);
        check_now("lock_hold", 4'b0010, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1);
        check_now("unlock_rot", 4'b0100, 1'b1);

        // sole requester keeps grant, then releases
        cycle(4'b0000, 4'b0000, 1'b0);
        repeat (50) cycle(4'b1000, 4'b0000, 1'b1);
        check_now("sole_hold", 4'b1000, 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1);
        check_now("sole_drop", 4'b0000, 1'b0);

        // reset pulse while 2 owns the bus
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b0100, 4'b0000, 1'b0);
        check_now("rst_revoke", 4'b0000, 1'b0);
        cycle(4'b0101, 4'b0000, 1'b1);
        check_now("ptr_reset", 4'b0001, 1'b1);

        // randomized traffic
        for (int t = 0; t < 600; t++) begin
            logic [3:0] r;
            logic [3:0] l;
            logic       rs;
            r  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15)) & 4'b0101;
            l  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rs = ($urandom_range(0, 60) != 0);
            cycle(r, l, rs);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
